// File: rtl/pong_pkg.sv
// Shared screen geometry and renderer FSM encoding for the Pong frame renderer.
package pong_pkg;

    localparam int SCREEN_W    = 128;
    localparam int SCREEN_H    = 64;
    localparam int PAGES       = 8;
    localparam int FRAME_BYTES = 1024;
    localparam int IDX_W       = $clog2(FRAME_BYTES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/pong_page_byte.sv
// Combinational SSD1306 page byte for one (page, col): bit n is row 8*page+n.
// Optional macro PONG_CENTER_NET_EN adds a dashed centre net at column 64.
module pong_page_byte
    import pong_pkg::*;
#(
    parameter int PADDLE_H  = 12,
    parameter int PADDLE_W  = 2,
    parameter int PADDLE_XL = 2,
    parameter int PADDLE_XR = 124,
    parameter int BALL_SZ   = 2
) (
    input  logic [2:0] page,
    input  logic [6:0] col,
    input  logic [5:0] paddle_l_y,
    input  logic [5:0] paddle_r_y,
    input  logic [6:0] ball_x,
    input  logic [5:0] ball_y,
    output logic [7:0] page_byte
);

    localparam logic [7:0] PH8 = 8'(PADDLE_H);
    localparam logic [7:0] PW8 = 8'(PADDLE_W);
    localparam logic [7:0] XL8 = 8'(PADDLE_XL);
    localparam logic [7:0] XR8 = 8'(PADDLE_XR);
    localparam logic [7:0] BS8 = 8'(BALL_SZ);
    localparam logic [7:0] NET_COL = 8'(SCREEN_W / 2);

    // 8-bit bounds: an extent past the screen edge simply matches no pixel.
    function automatic logic in_span(input logic [7:0] v, input logic [7:0] lo,
                                     input logic [7:0] len);
        return (v >= lo) && (v < lo + len);
    endfunction

    logic [7:0] col8;
    logic [7:0] row8;
    logic       l_col, r_col, b_col;

    always_comb begin
        page_byte = 8'h00;
        row8      = 8'h00;
        col8      = {1'b0, col};
        l_col     = in_span(col8, XL8, PW8);
        r_col     = in_span(col8, XR8, PW8);
        b_col     = in_span(col8, {1'b0, ball_x}, BS8);
        for (int n = 0; n < 8; n++) begin
            row8 = {2'b00, page, 3'(n)};
            page_byte[n] = (l_col && in_span(row8, {2'b00, paddle_l_y}, PH8)) ||
                           (r_col && in_span(row8, {2'b00, paddle_r_y}, PH8)) ||
                           (b_col && in_span(row8, {2'b00, ball_y}, BS8));
`ifdef PONG_CENTER_NET_EN
            if (col8 == NET_COL && !row8[2]) begin
                page_byte[n] = 1'b1;
            end
`endif
        end
    end

endmodule

// File: rtl/pong_frame_renderer.sv
// Streams one 1024-byte SSD1306 frame (horizontal addressing) per frame_req
// with valid/ready flow control. Optional macro: PONG_CENTER_NET_EN.
module pong_frame_renderer
    import pong_pkg::*;
#(
    parameter int PADDLE_H  = 12,
    parameter int PADDLE_W  = 2,
    parameter int PADDLE_XL = 2,
    parameter int PADDLE_XR = 124,
    parameter int BALL_SZ   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_req,
    input  logic [5:0] paddle_l_y,
    input  logic [5:0] paddle_r_y,
    input  logic [6:0] ball_x,
    input  logic [5:0] ball_y,
    output logic [7:0] o_data,
    output logic       o_valid,
    input  logic       i_ready,
    output logic       o_last,
    output logic       o_busy,
    output logic       o_frame_done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_nxt;
    logic [7:0]       data_q, next_byte;
    logic [5:0]       pl_q, pr_q, by_q, pl_sel, pr_sel, by_sel;
    logic [6:0]       bx_q, bx_sel;
    logic             hs, use_live;

    assign hs       = o_valid && i_ready;
    // Byte 0 is built from the live inputs on the same edge that latches them.
    assign use_live = (state_q == IDLE);
    assign idx_nxt  = use_live ? '0 : idx_q + IDX_W'(1);
    assign pl_sel   = use_live ? paddle_l_y : pl_q;
    assign pr_sel   = use_live ? paddle_r_y : pr_q;
    assign bx_sel   = use_live ? ball_x     : bx_q;
    assign by_sel   = use_live ? ball_y     : by_q;

    pong_page_byte #(
        .PADDLE_H (PADDLE_H),
        .PADDLE_W (PADDLE_W),
        .PADDLE_XL(PADDLE_XL),
        .PADDLE_XR(PADDLE_XR),
        .BALL_SZ  (BALL_SZ)
    ) u_page_byte (
        .page      (idx_nxt[9:7]),
        .col       (idx_nxt[6:0]),
        .paddle_l_y(pl_sel),
        .paddle_r_y(pr_sel),
        .ball_x    (bx_sel),
        .ball_y    (by_sel),
        .page_byte (next_byte)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (frame_req) state_d = STREAM;
            STREAM:  if (hs && idx_q == LAST_IDX) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            data_q  <= 8'h00;
            pl_q    <= '0;
            pr_q    <= '0;
            bx_q    <= '0;
            by_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && frame_req) begin
                pl_q   <= paddle_l_y;
                pr_q   <= paddle_r_y;
                bx_q   <= ball_x;
                by_q   <= ball_y;
                idx_q  <= '0;
                data_q <= next_byte;
            end else if (state_q == STREAM && hs) begin
                if (idx_q == LAST_IDX) begin
                    idx_q  <= '0;
                    data_q <= 8'h00;
                end else begin
                    idx_q  <= idx_nxt;
                    data_q <= next_byte;
                end
            end
        end
    end

    assign o_data       = data_q;
    assign o_valid      = (state_q == STREAM);
    assign o_last       = o_valid && (idx_q == LAST_IDX);
    assign o_busy       = (state_q != IDLE);
    assign o_frame_done = (state_q == DONE);

endmodule

// File: tb/tb_pong_frame_renderer.sv
// Directed, table-driven bench for pong_frame_renderer (honours PONG_CENTER_NET_EN).
module tb_pong_frame_renderer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       frame_req;
    logic [5:0] paddle_l_y, paddle_r_y, ball_y;
    logic [6:0] ball_x;
    logic [7:0] o_data;
    logic       o_valid, i_ready, o_last, o_busy, o_frame_done;

    pong_frame_renderer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_req   (frame_req),
        .paddle_l_y  (paddle_l_y),
        .paddle_r_y  (paddle_r_y),
        .ball_x      (ball_x),
        .ball_y      (ball_y),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_last      (o_last),
        .o_busy      (o_busy),
        .o_frame_done(o_frame_done)
    );

    always #5 clk = ~clk;

`ifdef PONG_CENTER_NET_EN
    localparam logic [7:0] NET_B = 8'h0F;
`else
    localparam logic [7:0] NET_B = 8'h00;
`endif

    typedef struct {
        int         pl, pr, bx, by, idx;
        logic [7:0] exp;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] got[1024];
    int         n_cmp = 0;
    int         n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Pixel-level reference of the screen contents.
    function automatic logic [7:0] model(int idx, int pl, int pr, int bx, int by);
        logic [7:0] b;
        int page, col, row;
        b    = 8'h00;
        page = idx / 128;
        col  = idx % 128;
        for (int k = 0; k < 8; k++) begin
            row = page * 8 + k;
            if ((col >= 2 && col < 4 && row >= pl && row < pl + 12) ||
                (col >= 124 && col < 126 && row >= pr && row < pr + 12) ||
                (col >= bx && col < bx + 2 && row >= by && row < by + 2))
                b[k] = 1'b1;
`ifdef PONG_CENTER_NET_EN
            if (col == 64 && (row % 8) < 4) b[k] = 1'b1;
`endif
        end
        return b;
    endfunction

    // Leaves the bench at the negedge of the DONE cycle.
    task automatic run_frame(input bit rnd, input bit hold, input bit chg);
        int n, cyc, stall, errs, mism;
        int spl, spr, sbx, sby;
        bit stalled;
        logic [7:0] pd;
        logic plast;
        spl = int'(paddle_l_y); spr = int'(paddle_r_y);
        sbx = int'(ball_x);     sby = int'(ball_y);
        @(negedge clk);
        frame_req = 1'b1;
        @(negedge clk);
        if (!hold) frame_req = 1'b0;
        chk("latency_valid", o_valid, 1);
        n = 0; cyc = 0; stall = 0; errs = 0; stalled = 0; pd = 8'h00; plast = 1'b0;
        while (n < 1024 && cyc < 6000) begin
            if (chg && n == 100) begin
                paddle_l_y = 6'd33; paddle_r_y = 6'd1; ball_x = 7'd64; ball_y = 6'd20;
            end
            if (!rnd) i_ready = 1'b1;
            else if (n == 500 && stall < 5) begin
                i_ready = 1'b0;
                stall++;
            end else i_ready = 1'($urandom_range(0, 1));
            if (stalled && (o_data !== pd || o_last !== plast)) errs++;
            if (o_frame_done !== 1'b0 || o_valid !== 1'b1 || o_busy !== 1'b1) errs++;
            if (o_valid && i_ready) begin
                if (o_last !== (n == 1023)) errs++;
                got[n] = o_data;
                n++;
            end
            stalled = o_valid && !i_ready;
            pd      = o_data;
            plast   = o_last;
            cyc++;
            @(negedge clk);
        end
        i_ready = 1'b1;
        chk("stream_protocol", errs, 0);
        chk("byte_count", n, 1024);
        if (rnd) chk("stall_at_500", stall, 5);
        mism = 0;
        for (int i = 0; i < n; i++)
            if (got[i] !== model(i, spl, spr, sbx, sby)) mism++;
        chk("frame_bytes", mism, 0);
        chk("done_pulse", o_frame_done, 1);
        chk("done_busy", o_busy, 1);
    endtask

    task automatic after_done();
        @(negedge clk);
        chk("done_once", o_frame_done, 0);
        chk("idle_busy", o_busy, 0);
    endtask

    initial begin
        int cpl, cpr, cbx, cby;
        rst_n = 1'b0; frame_req = 1'b0; i_ready = 1'b1;
        paddle_l_y = '0; paddle_r_y = '0; ball_x = '0; ball_y = '0;

        vecs.push_back('{0, 0, 127, 63, 0,    8'h00});
        vecs.push_back('{0, 0, 127, 63, 2,    8'hFF});
        vecs.push_back('{0, 0, 127, 63, 3,    8'hFF});
        vecs.push_back('{0, 0, 127, 63, 4,    8'h00});
        vecs.push_back('{0, 0, 127, 63, 124,  8'hFF});
        vecs.push_back('{0, 0, 127, 63, 126,  8'h00});
        vecs.push_back('{0, 0, 127, 63, 127,  8'h00});
        vecs.push_back('{0, 0, 127, 63, 130,  8'h0F});
        vecs.push_back('{0, 0, 127, 63, 896,  8'h00});
        vecs.push_back('{0, 0, 127, 63, 1022, 8'h00});
        vecs.push_back('{0, 0, 127, 63, 1023, 8'h80});
        vecs.push_back('{60, 0, 127, 63, 898, 8'hF0});
        vecs.push_back('{60, 0, 127, 63, 899, 8'hF0});
        vecs.push_back('{60, 0, 127, 63, 2,   8'h00});
        vecs.push_back('{60, 0, 127, 63, 3,   8'h00});
        vecs.push_back('{60, 0, 127, 63, 770, 8'h00});
        vecs.push_back('{0, 30, 10, 7, 10,    8'h80});
        vecs.push_back('{0, 30, 10, 7, 11,    8'h80});
        vecs.push_back('{0, 30, 10, 7, 12,    8'h00});
        vecs.push_back('{0, 30, 10, 7, 138,   8'h01});
        vecs.push_back('{0, 30, 10, 7, 509,   8'hC0});
        vecs.push_back('{0, 30, 10, 7, 764,   8'h03});
        vecs.push_back('{0, 30, 10, 7, 64,    NET_B});
        vecs.push_back('{0, 30, 10, 7, 960,   NET_B});
        vecs.push_back('{0, 0, 10, 5, 10,     8'h60});
        vecs.push_back('{0, 0, 10, 5, 1,      8'h00});

        #12;
        chk("rst_valid", o_valid, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_data", o_data, 0);
        chk("rst_last", o_last, 0);
        chk("rst_done", o_frame_done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_no_req", o_valid, 0);

        cpl = -1; cpr = -1; cbx = -1; cby = -1;
        foreach (vecs[i]) begin
            if (vecs[i].pl != cpl || vecs[i].pr != cpr || vecs[i].bx != cbx || vecs[i].by != cby) begin
                cpl = vecs[i].pl; cpr = vecs[i].pr; cbx = vecs[i].bx; cby = vecs[i].by;
                paddle_l_y = 6'(cpl); paddle_r_y = 6'(cpr);
                ball_x = 7'(cbx);     ball_y = 6'(cby);
                run_frame(1'b0, 1'b0, 1'b0);
                after_done();
            end
            chk($sformatf("vec%0d_idx%0d", i, vecs[i].idx), got[vecs[i].idx], vecs[i].exp);
        end

        // Random backpressure with a 5-cycle stall at byte 500.
        paddle_l_y = 6'd17; paddle_r_y = 6'd45; ball_x = 7'd70; ball_y = 6'd33;
        run_frame(1'b1, 1'b0, 1'b0);
        after_done();

        // Asynchronous reset in the middle of a frame.
        paddle_l_y = 6'd5; paddle_r_y = 6'd50; ball_x = 7'd30; ball_y = 6'd40;
        @(negedge clk);
        frame_req = 1'b1;
        @(negedge clk);
        frame_req = 1'b0;
        repeat (300) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_valid", o_valid, 0);
        chk("midrst_busy", o_busy, 0);
        chk("midrst_data", o_data, 0);
        chk("midrst_last", o_last, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("no_resume", o_valid, 0);
        run_frame(1'b0, 1'b0, 1'b0);
        after_done();

        // frame_req held high and live positions changed mid-frame.
        paddle_l_y = 6'd0; paddle_r_y = 6'd60; ball_x = 7'd126; ball_y = 6'd62;
        run_frame(1'b0, 1'b1, 1'b1);
        @(negedge clk);
        chk("hold_done_once", o_frame_done, 0);
        chk("hold_idle_valid", o_valid, 0);
        chk("hold_idle_busy", o_busy, 0);
        @(negedge clk);
        chk("hold_restart", o_valid, 1);
        frame_req = 1'b0;
        begin
            int cyc;
            cyc = 0;
            while (o_busy && cyc < 3000) begin
                @(negedge clk);
                cyc++;
            end
            chk("drain_timeout", (cyc < 3000), 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
